// File: rtl/stream_demux.sv
// Registered 1-to-NCH valid/ready demultiplexer. Each output channel owns a
// one-entry register, so a stall on one channel never disturbs another.

module stream_demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (load) data <= din;
      // load wins over drain so a same-edge drain+load keeps the new beat
      if (clr)        valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (drain) valid <= 1'b0;
    end
  end
endmodule

module stream_demux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode_rr,
  input  logic                 flush,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [SELW-1:0]      rr_ptr,
  output logic [CNTW-1:0]      acc_cnt
);
  logic [SELW-1:0]             tgt;
  logic                        accept;
  logic [NCH-1:0][WIDTH-1:0]   data_q;

  assign tgt      = mode_rr ? rr_ptr : in_sel;
  assign in_ready = !flush && (!out_valid[tgt] || out_ready[tgt]);
  assign accept   = in_valid && in_ready;
  assign out_data = data_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    stream_demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept && (tgt == SELW'(gi))),
      .drain (out_valid[gi] && out_ready[gi]),
      .clr   (flush),
      .din   (in_data),
      .data  (data_q[gi]),
      .valid (out_valid[gi])
    );
  end

  // NCH is a power of two, so natural SELW-bit overflow gives the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      if (mode_rr) rr_ptr <= rr_ptr + SELW'(1);
      if (acc_cnt != {CNTW{1'b1}}) acc_cnt <= acc_cnt + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: vector table plus hand sequences, with a per-beat
// scoreboard that checks each drained beat lands on the right channel.

module tb_stream_demux;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;
  localparam int C = 4;
  localparam int CMAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic [S-1:0]     in_sel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mode_rr = 1'b0;
  logic             flush = 1'b0;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready = '0;
  logic [S-1:0]     rr_ptr;
  logic [C-1:0]     acc_cnt;

  stream_demux #(.WIDTH(W), .NCH(N), .SELW(S), .CNTW(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .mode_rr(mode_rr), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rr_ptr(rr_ptr), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [S-1:0] sel;
    logic         rr;
    logic [N-1:0] ordy;
    logic         fl;
    logic         exp_rdy;
  } vec_t;

  typedef struct {
    int           ch;
    logic [W-1:0] d;
  } sb_t;

  int total = 0;
  int bad   = 0;
  sb_t sb[$];
  vec_t tbl[$];
  logic [N-1:0] m_valid;
  logic [S-1:0] m_rr;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic [S-1:0] sel,
                              input logic rr, input logic [N-1:0] ordy, input logic fl,
                              input logic exp_rdy);
    vec_t t;
    t.v = v; t.d = d; t.sel = sel; t.rr = rr; t.ordy = ordy; t.fl = fl; t.exp_rdy = exp_rdy;
    return t;
  endfunction

  // One cycle: drive, check pre-edge outputs against the model, advance model.
  task automatic step(input vec_t t);
    logic [S-1:0] tgt;
    logic rdy;
    int idx;
    @(negedge clk);
    in_valid = t.v; in_data = t.d; in_sel = t.sel; mode_rr = t.rr;
    out_ready = t.ordy; flush = t.fl;
    #1;
    tgt = t.rr ? m_rr : t.sel;
    rdy = !t.fl && (!m_valid[tgt] || t.ordy[tgt]);
    chk("in_ready", 32'(in_ready), 32'(t.exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("rr_ptr", 32'(rr_ptr), 32'(m_rr));
    chk("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
    for (int ch = 0; ch < N; ch++) begin
      if (m_valid[ch] && t.ordy[ch]) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].ch == ch) idx = k;
        if (idx < 0) begin
          chk("drain_sb_empty", 32'(ch), 32'hFFFF);
        end else begin
          chk($sformatf("drain_data_ch%0d", ch), 32'(out_data[ch*W +: W]), 32'(sb[idx].d));
          sb.delete(idx);
        end
        m_valid[ch] = 1'b0;
      end
    end
    if (t.fl) begin
      m_valid = '0;
      sb.delete();
    end
    if (t.v && rdy) begin
      m_valid[tgt] = 1'b1;
      sb.push_back('{ch: int'(tgt), d: t.d});
      if (t.rr) m_rr = m_rr + 1'b1;
      if (m_cnt < CMAX) m_cnt++;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; mode_rr = 1'b0; in_sel = '0; out_ready = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_valid = '0; m_rr = '0; m_cnt = 0; sb.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'h0);
  endtask

  initial begin
    do_reset();

    // select mode, all ready
    tbl.push_back(mk(1, 8'hA0, 2, 0, 4'hF, 0, 1));
    tbl.push_back(mk(1, 8'hA1, 0, 0, 4'hF, 0, 1));
    tbl.push_back(mk(1, 8'hA2, 3, 0, 4'hF, 0, 1));
    tbl.push_back(mk(1, 8'hA3, 1, 0, 4'hF, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'hF, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'hF, 0, 1));
    // backpressure on channel 1
    tbl.push_back(mk(1, 8'h11, 1, 0, 4'hD, 0, 1));
    tbl.push_back(mk(1, 8'h22, 1, 0, 4'hD, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 0, 4'hD, 0, 1));
    tbl.push_back(mk(1, 8'h22, 1, 0, 4'hF, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 4'hF, 0, 1));
    // round-robin wrap then back to select mode
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, W'(i), 0, 1, 4'hF, 0, 1));
    tbl.push_back(mk(1, 8'h66, 3, 0, 4'hF, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'hF, 0, 1));
    foreach (tbl[i]) step(tbl[i]);
    @(negedge clk); #1;
    chk("acc_after_table", 32'(acc_cnt), 32'd14);
    chk("rr_after_table", 32'(rr_ptr), 32'd2);

    // flush with in_valid high, then full-rate throughput into one channel
    do_reset();
    step(mk(1, 8'h40, 0, 0, 4'h0, 0, 1));
    step(mk(1, 8'h42, 2, 0, 4'h0, 0, 1));
    step(mk(1, 8'h99, 1, 0, 4'h0, 1, 0));
    step(mk(0, 8'h00, 0, 0, 4'h0, 0, 1));
    for (int i = 0; i < 10; i++) step(mk(1, W'(8'h50 + i), 0, 0, 4'h1, 0, 1));
    step(mk(0, 8'h00, 0, 0, 4'h1, 0, 1));
    @(negedge clk); #1;
    chk("acc_after_flush", 32'(acc_cnt), 32'd12);

    // saturation
    for (int i = 0; i < 20; i++) step(mk(1, W'(8'h80 + i), 0, 1, 4'hF, 0, 1));
    step(mk(0, 8'h00, 0, 0, 4'hF, 0, 1));
    @(negedge clk); #1;
    chk("acc_saturated", 32'(acc_cnt), 32'd15);

    // async reset between edges with channels full
    step(mk(1, 8'h77, 0, 0, 4'h0, 0, 1));
    step(mk(1, 8'h78, 3, 0, 4'h0, 0, 1));
    @(negedge clk); #1;
    chk("full_before_reset", 32'(out_valid), 32'h9);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_data", out_data, 32'h0);
    chk("async_rst_acc", 32'(acc_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
